// File: rtl/snitch_perf_cnt_unit.sv
// Per-core event counters with wrap/saturate modes, per-event masking, sticky
// overflow flags with a maskable interrupt, and a single-outstanding register port.
module snitch_perf_cnt_unit #(
  parameter int unsigned NrCores      = 4,
  parameter int unsigned NrEvents     = 4,
  parameter int unsigned CounterWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NrCores*NrEvents-1:0]  events_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [11:0]                  req_addr_i,
  input  logic                         req_write_i,
  input  logic [31:0]                  req_wdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [31:0]                  rsp_data_o,
  output logic                         rsp_error_o,
  output logic                         overflow_irq_o
);

  localparam int unsigned NrCounters = NrCores * NrEvents;

  localparam logic [9:0] WordClear   = 10'h3FB;
  localparam logic [9:0] WordCtrl    = 10'h3FC;
  localparam logic [9:0] WordEvmask  = 10'h3FD;
  localparam logic [9:0] WordOvf     = 10'h3FE;
  localparam logic [9:0] WordIrqmask = 10'h3FF;

  if (NrCounters > 32 || NrCounters == 0) begin : g_bad_counter_count
    $error("NrCores*NrEvents must be in 1..32");
  end
  if (CounterWidth > 32 || CounterWidth == 0) begin : g_bad_counter_width
    $error("CounterWidth must be in 1..32");
  end

  // Handshake: a request transfers when req_valid_i && req_ready_o; a response
  // transfers when rsp_valid_o && rsp_ready_i. Only one response is ever held,
  // so a new request is taken only if the held response leaves this cycle.

  logic [CounterWidth-1:0] cnt_q [NrCounters];
  logic [CounterWidth-1:0] cnt_d [NrCounters];
  logic [NrCounters-1:0]   held_q, held_d;
  logic [1:0]              ctrl_q, ctrl_d;
  logic [NrEvents-1:0]     evmask_q, evmask_d;
  logic [NrCounters-1:0]   ovf_q, ovf_d;
  logic [NrCounters-1:0]   irqmask_q, irqmask_d;
  logic                    irq_q, irq_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_data_q, rsp_data_d;
  logic                    rsp_error_q, rsp_error_d;

  logic                  acc;
  logic [9:0]            word;
  logic                  hit_cnt, hit_ctrl, hit_evmask, hit_ovf, hit_irqmask, hit_clear;
  logic                  hit_any;
  logic                  wr_ok;
  logic [NrCounters-1:0] cnt_we;
  logic                  clear_we;
  logic [NrCounters-1:0] inc;
  logic [NrCounters-1:0] ovf_set;
  logic [NrCounters-1:0] ovf_clr;
  logic [31:0]           rdata;
  logic [31:0]           evmask_rd, ovf_rd, irqmask_rd;

  logic unused_addr;
  logic unused_wdata;
  assign unused_addr  = ^req_addr_i[1:0];
  assign unused_wdata = ^req_wdata_i;

  assign req_ready_o    = !rsp_valid_q | rsp_ready_i;
  assign acc            = req_valid_i & req_ready_o;
  assign word           = req_addr_i[11:2];
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_error_o    = rsp_error_q;
  assign overflow_irq_o = irq_q;

  always_comb begin : zero_extend
    evmask_rd  = '0;
    ovf_rd     = '0;
    irqmask_rd = '0;
    evmask_rd[NrEvents-1:0]    = evmask_q;
    ovf_rd[NrCounters-1:0]     = ovf_q;
    irqmask_rd[NrCounters-1:0] = irqmask_q;
  end

  // Address decode and read mux; counter words never overlap the control block.
  always_comb begin : decode
    hit_cnt = 1'b0;
    cnt_we  = '0;
    rdata   = '0;
    for (int unsigned i = 0; i < NrCounters; i++) begin
      if (word == 10'(i)) begin
        hit_cnt   = 1'b1;
        cnt_we[i] = acc & req_write_i;
        rdata     = '0;
        rdata[CounterWidth-1:0] = cnt_q[i];
      end
    end
    hit_ctrl    = (word == WordCtrl);
    hit_evmask  = (word == WordEvmask);
    hit_ovf     = (word == WordOvf);
    hit_irqmask = (word == WordIrqmask);
    hit_clear   = (word == WordClear);
    if (hit_ctrl)    rdata = {30'b0, ctrl_q};
    if (hit_evmask)  rdata = evmask_rd;
    if (hit_ovf)     rdata = ovf_rd;
    if (hit_irqmask) rdata = irqmask_rd;
    if (hit_clear)   rdata = '0;
    hit_any  = hit_cnt | hit_ctrl | hit_evmask | hit_ovf | hit_irqmask | hit_clear;
    wr_ok    = acc & req_write_i & hit_any;
    clear_we = wr_ok & hit_clear;
  end

  // Per-counter next state: clear beats write beats increment.
  always_comb begin : count_next
    inc     = '0;
    ovf_set = '0;
    held_d  = held_q;
    for (int unsigned i = 0; i < NrCounters; i++) begin
      inc[i]   = events_i[i] & ctrl_q[0] & evmask_q[i % NrEvents];
      cnt_d[i] = cnt_q[i];
      if (clear_we) begin
        cnt_d[i]  = '0;
        held_d[i] = 1'b0;
      end else if (cnt_we[i]) begin
        cnt_d[i]  = req_wdata_i[CounterWidth-1:0];
        held_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (!(&cnt_q[i])) begin
          cnt_d[i]  = cnt_q[i] + CounterWidth'(1);
          held_d[i] = 1'b0;
        end else if (ctrl_q[1]) begin
          // Saturated counters flag once; further strobes while pinned are silent.
          ovf_set[i] = !held_q[i];
          held_d[i]  = 1'b1;
        end else begin
          cnt_d[i]   = '0;
          ovf_set[i] = 1'b1;
          held_d[i]  = 1'b0;
        end
      end
    end
  end

  always_comb begin : cfg_next
    ctrl_d    = ctrl_q;
    evmask_d  = evmask_q;
    irqmask_d = irqmask_q;
    ovf_clr   = '0;
    if (wr_ok && hit_ctrl)    ctrl_d    = req_wdata_i[1:0];
    if (wr_ok && hit_evmask)  evmask_d  = req_wdata_i[NrEvents-1:0];
    if (wr_ok && hit_irqmask) irqmask_d = req_wdata_i[NrCounters-1:0];
    if (wr_ok && hit_ovf)     ovf_clr   = req_wdata_i[NrCounters-1:0];
    // A fresh overflow wins over a same-cycle write-1-to-clear.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    irq_d = |(ovf_q & irqmask_q);
  end

  always_comb begin : rsp_next
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    if (acc) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = !hit_any;
      rsp_data_d  = (!req_write_i && hit_any) ? rdata : 32'h0;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrCounters; i++) cnt_q[i] <= '0;
      held_q      <= '0;
      ctrl_q      <= 2'b01;
      evmask_q    <= '1;
      ovf_q       <= '0;
      irqmask_q   <= '0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NrCounters; i++) cnt_q[i] <= cnt_d[i];
      held_q      <= held_d;
      ctrl_q      <= ctrl_d;
      evmask_q    <= evmask_d;
      ovf_q       <= ovf_d;
      irqmask_q   <= irqmask_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
